// File: rtl/anubis_dec_key_prep_pkg.sv
// Shared definitions for the Anubis decryption key-preparation block.
// Holds the GF(2^8) reduction constant, the default round count, the
// 128-bit key type, the FSM state type and the GF doubling helper.
package anubis_dec_key_prep_pkg;

  // Low byte of the Anubis field polynomial x^8+x^4+x^3+x^2+1 (0x11D).
  localparam logic [7:0] ANUBIS_POLY = 8'h1D;

  // Round count for a 128-bit cipher key.
  localparam int DEFAULT_ROUNDS = 12;

  typedef logic [127:0] key_t;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_PRIME = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  // Multiply by 2 in GF(2^8) modulo 0x11D.
  function automatic logic [7:0] gf_x2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? ANUBIS_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/anubis_dec_key_prep_theta.sv
// anubis_key_theta: Anubis theta linear layer on a 128-bit key.
// Latency: purely combinational. Backpressure: none (no state).
// Ports: key  - 128-bit input key, four 32-bit rows of four bytes each.
//        mixed - theta(key); theta is its own inverse.
module anubis_key_theta
  import anubis_dec_key_prep_pkg::*;
(
  input  key_t key,
  output key_t mixed
);

  for (genvar g = 0; g < 4; g++) begin : g_row
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] s13, s02, s23, s01;

    assign b0 = key[32*g +  0 +: 8];
    assign b1 = key[32*g +  8 +: 8];
    assign b2 = key[32*g + 16 +: 8];
    assign b3 = key[32*g + 24 +: 8];

    // Pairwise sums shared between output bytes.
    assign s13 = b1 ^ b3;
    assign s02 = b0 ^ b2;
    assign s23 = b2 ^ b3;
    assign s01 = b0 ^ b1;

    assign mixed[32*g +  0 +: 8] = b0 ^ gf_x2(s13) ^ gf_x2(gf_x2(s23));
    assign mixed[32*g +  8 +: 8] = b1 ^ gf_x2(s02) ^ gf_x2(gf_x2(s23));
    assign mixed[32*g + 16 +: 8] = b2 ^ gf_x2(s13) ^ gf_x2(gf_x2(s01));
    assign mixed[32*g + 24 +: 8] = b3 ^ gf_x2(s02) ^ gf_x2(gf_x2(s01));
  end

endmodule

// File: rtl/anubis_dec_key_prep.sv
// anubis_dec_key_prep: turns the encryption round-key stream K^0..K^R into
// the decryption stream K'^0..K'^R (reverse order, theta on middle keys).
// Latency: first out_valid 2 cycles after the last input accept; then one
// key per cycle. Backpressure: out_ready low freezes the output; input is
// refused (in_ready=0) from the last accept until the final key is taken.
// Ports: clk/rst (async active-high); in_valid/in_ready/in_key producer
// side; out_valid/out_ready/out_key/out_idx/out_last consumer side; busy.
module anubis_dec_key_prep
  import anubis_dec_key_prep_pkg::*;
#(
  parameter int ROUNDS = DEFAULT_ROUNDS,
  // Must satisfy 2**IDX_W >= ROUNDS+1.
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_key,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS);

  state_t           state, state_nx;
  logic [IDX_W-1:0] wcnt;
  key_t             mem [0:ROUNDS];

  logic             wr_en;
  logic             ld_key;
  logic             done;

  logic [IDX_W-1:0] nxt_idx;
  logic [IDX_W-1:0] rd_addr;
  logic             rd_raw;
  key_t             rd_dat;
  key_t             rd_mixed;
  key_t             rd_key;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    wr_en     = 1'b0;
    ld_key    = 1'b0;
    done      = 1'b0;
    case (state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en = 1'b1;
          if (wcnt == LAST) state_nx = ST_PRIME;
        end
      end
      ST_PRIME: begin
        ld_key   = 1'b1;
        state_nx = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (out_idx == LAST) begin
            done     = 1'b1;
            state_nx = ST_LOAD;
          end else begin
            ld_key = 1'b1;
          end
        end
      end
      default: state_nx = ST_LOAD;
    endcase
  end

  assign out_last = (state == ST_OUT) && (out_idx == LAST);
  assign busy     = !((state == ST_LOAD) && (wcnt == '0));

  // ---------------- key buffer ----------------
  // Contents need no reset: wcnt=0 already marks the buffer empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wcnt] <= in_key;
  end

  // Read address walks the buffer backwards. PRIME fetches the top entry;
  // in OUT the address is derived from the index about to be presented.
  // The final key (K^0) and the first key (K^R) bypass theta.
  assign nxt_idx = out_idx + IDX_W'(1);

  always_comb begin
    rd_addr = LAST;
    rd_raw  = 1'b1;
    if ((state == ST_OUT) && (out_idx != LAST)) begin
      rd_addr = LAST - nxt_idx;
      rd_raw  = (nxt_idx == LAST);
    end
  end

  assign rd_dat = mem[rd_addr];

  anubis_key_theta u_theta (
    .key   (rd_dat),
    .mixed (rd_mixed)
  );

  assign rd_key = rd_raw ? rd_dat : rd_mixed;

  // ---------------- counters and output register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt    <= '0;
      out_key <= '0;
      out_idx <= '0;
    end else begin
      if (wr_en)     wcnt <= wcnt + IDX_W'(1);
      else if (done) wcnt <= '0;

      if (ld_key) begin
        out_key <= rd_key;
        out_idx <= (state == ST_PRIME) ? '0 : nxt_idx;
      end
    end
  end

endmodule

// File: tb/tb_anubis_dec_key_prep.sv
module tb_anubis_dec_key_prep;
  import anubis_dec_key_prep_pkg::*;

  localparam int R  = 12;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_key;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_key;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          busy;

  anubis_dec_key_prep #(.ROUNDS(R), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_key   (out_key),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_pass = 0;
  key_t kin  [0:R];   // keys to load next
  key_t kref [0:R];   // encryption keys of the stream being drained
  key_t kexp [0:R];   // expected decryption stream
  key_t kobs [0:R];   // observed decryption stream

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Generic GF(2^8) product modulo x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [8:0] x;
    p = 8'h00;
    x = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x[7:0];
      x = x << 1;
      if (x[8]) x = x ^ 9'h11D;
    end
    return p;
  endfunction

  // Theta as the Hadamard matrix had(1,2,4,6): c_j = sum_k h[j^k] * b_k.
  function automatic key_t theta_m(input key_t x);
    key_t       y;
    logic [7:0] h [4];
    logic [7:0] acc;
    h = '{8'h01, 8'h02, 8'h04, 8'h06};
    y = '0;
    for (int w = 0; w < 4; w++) begin
      for (int j = 0; j < 4; j++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(h[j ^ k], x[32*w + 8*k +: 8]);
        y[32*w + 8*j +: 8] = acc;
      end
    end
    return y;
  endfunction

  function automatic key_t rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic build_exp();
    for (int r = 0; r <= R; r++) kref[r] = kin[r];
    for (int r = 0; r <= R; r++) begin
      if (r == 0)      kexp[r] = kref[R];
      else if (r == R) kexp[r] = kref[0];
      else             kexp[r] = theta_m(kref[R - r]);
    end
  endtask

  task automatic rand_stream();
    for (int i = 0; i <= R; i++) kin[i] = rand_key();
  endtask

  // Feed kin[0..R]; returns just after the edge of the final accept, then
  // checks the PRIME cycle.
  task automatic load_stream(input int gaps);
    int i;
    int cyc;
    i = 0;
    cyc = 0;
    while (i <= R) begin
      @(negedge clk);
      cyc++;
      if (cyc > 200) begin
        chk("load_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
        return;
      end
      chk($sformatf("load_in_ready[%0d]", i), in_ready, 1'b1);
      chk($sformatf("load_busy[%0d]", i), busy, (i != 0));
      in_valid = (gaps != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_key   = in_valid ? kin[i] : rand_key();
      @(posedge clk);
      if (in_valid) i++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("prime_out_valid", out_valid, 1'b0);
    chk("prime_in_ready", in_ready, 1'b0);
    chk("prime_busy", busy, 1'b1);
  endtask

  // Consume the output stream. mode 0: ready always, 1: ready 1,0,0,1,
  // 2: random. stop_at >= 0 returns at that index without consuming it.
  // hold_in keeps kin[0] offered on the input throughout.
  task automatic drain(input int mode, input int stop_at, input int hold_in);
    int r;
    int cyc;
    r = 0;
    cyc = 0;
    while (r <= R) begin
      @(negedge clk);
      cyc++;
      if (cyc > 400) begin
        chk("drain_timeout", 1'b0, 1'b1);
        return;
      end
      chk($sformatf("out_valid[%0d]", r), out_valid, 1'b1);
      chk($sformatf("out_idx[%0d]", r), out_idx, r);
      chk($sformatf("out_key[%0d]", r), out_key, kexp[r]);
      chk($sformatf("out_last[%0d]", r), out_last, (r == R));
      chk($sformatf("out_in_ready[%0d]", r), in_ready, 1'b0);
      if (r > 0 && r < R)
        chk($sformatf("recover[%0d]", r), theta_m(out_key), kref[R - r]);
      kobs[r] = out_key;
      if (r == stop_at) return;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 1) || ((cyc % 4) == 0);
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (hold_in != 0) begin
        in_valid = 1'b1;
        in_key   = kin[0];
      end
      @(posedge clk);
      if (out_ready) r++;
    end
    if (mode == 0) chk("throughput_cycles", cyc, R + 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_key    = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_key", out_key, 128'h0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Stream 1: K^i = {16{i}}, continuous ready.
    for (int i = 0; i <= R; i++) kin[i] = {16{i[7:0]}};
    build_exp();
    load_stream(0);
    drain(0, -1, 0);

    // Stream 2: theta vectors planted in the middle keys, ready 1,0,0,1.
    rand_stream();
    kin[R-1] = {4{32'h0000_0001}};
    kin[R-2] = {4{32'h0000_0080}};
    build_exp();
    load_stream(0);
    drain(1, -1, 0);
    chk("theta_unit", kobs[1], {4{32'h0604_0201}});
    chk("theta_reduce", kobs[2], {4{32'h273A_1D80}});

    // Stream 3: gappy input, random ready, next stream's first key held.
    rand_stream();
    build_exp();
    load_stream(1);
    rand_stream();
    drain(2, -1, 1);

    // Stream 4: held key must be taken in the first LOAD cycle.
    build_exp();
    load_stream(0);
    drain(2, -1, 0);

    // Stream 5: reset while presenting index 5.
    rand_stream();
    build_exp();
    load_stream(1);
    drain(0, 5, 0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_out_idx", out_idx, 0);
    chk("midrst_out_last", out_last, 1'b0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b0;

    // Stream 6: fresh stream after the abandoned one.
    rand_stream();
    build_exp();
    load_stream(0);
    drain(2, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
